stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
Shares one 8-bit LIFO stack (push/pop/data_in/data_out/error interface) between NUM_REQ requesters using round-robin arbitration. Serialises one stack operation at a time and tracks occupancy, so overflow and underflow are refused before they reach the stack. Returns pop data and a status to the granted requester. Sits between client logic and the stack instance and owns all of the stack's control inputs.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DEPTH, 16, stack capacity in entries; must match the stack instance
DATA_W, 8, data width
STACK_LAT, 1, cycles from stk_pop being sampled by the stack until stk_data_out holds the popped value (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_push  in  NUM_REQ  per-requester push request, level
req_pop  in  NUM_REQ  per-requester pop request, level
req_data  in  NUM_REQ*DATA_W  push data; slice i belongs to requester i
flush  in  1  clear-stack request, level
rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
rsp_data  out  DATA_W  popped value, valid with rsp_valid
rsp_err  out  1  status with rsp_valid: 1 = refused (full, empty or illegal)
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_data_in  out  DATA_W  to stack data_in
stk_clear  out  1  to stack reset; equals reset OR the internal flush pulse
stk_data_out  in  DATA_W  from stack data_out
stk_error  in  1  from stack error
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count==DEPTH
empty  out  1  count==0
busy  out  1  FSM not in IDLE
fault  out  1  sticky; stk_error seen on a cycle with no legal operation issued

Behaviour:
- Reset (async, active-high): FSM=IDLE, count=0, rr_ptr=0, fault=0. All outputs 0, except empty=1 and stk_clear=1 while reset is high.
- States: IDLE, ISSUE, WAIT, RESP, FLUSH.
- IDLE, flush=1: go to FLUSH. Flush has priority over all requests.
- IDLE, any request pending: the round-robin winner is the first requester i at or after rr_ptr with req_push[i]|req_pop[i]. The winner index and opcode are latched, and req_data slice i is latched for a push.
- Legality check in IDLE:
  - push and pop both set for the winner → illegal, go to RESP with err=1.
  - Push with full=1, or pop with empty=1 → go to RESP with err=1. The stack is not touched.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): drive exactly one of stk_push/stk_pop for that cycle; stk_data_in = latched data. count is updated at the end of this cycle (+1 for push, -1 for pop).
  - Push → RESP.
  - Pop → WAIT.
- WAIT: lasts STACK_LAT cycles. stk_data_out is captured on the last WAIT cycle, then go to RESP.
- RESP (1 cycle): rsp_valid[winner]=1, with rsp_err and rsp_data. rsp_data=0 on a push or on any error. rr_ptr=(winner+1) mod NUM_REQ. Go to IDLE.
- Latency, with request first seen in IDLE at cycle 0:
  - Error response: rsp_valid at cycle 1.
  - Push: stk_push at cycle 1, rsp_valid at cycle 2.
  - Pop: stk_pop at cycle 1, rsp_valid at cycle 2+STACK_LAT.
- Requester protocol:
  - Hold the request and data stable until its rsp_valid.
  - The cycle after rsp_valid, the requester either drops the request or presents a new one.
  - A request withdrawn before its grant is a protocol violation; behaviour is undefined.
- FLUSH (1 cycle): stk_clear=1, count←0, then IDLE. No rsp_valid is generated.
- stk_push and stk_pop are never high in the same cycle, and are never high outside ISSUE.
- fault is set if stk_error=1 in any cycle other than the cycle after ISSUE. Only reset clears it.
- Reset mid-operation aborts the transaction; no response is issued for it.

Decomposition:
- Package stack_arbiter_pkg holds:
  - State enum: IDLE, ISSUE, WAIT, RESP, FLUSH.
  - Opcode enum: OP_PUSH, OP_POP.
  - Response-code constants.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: request vector, rr_ptr, enable.
  - Outputs: one-hot grant, binary index, any.
  - Purely combinational; rr_ptr is kept in stack_arbiter.

Test Plan:
1. Requester 0 pushes 8'hAA → stk_push pulses at cycle 1; rsp_valid=2'b01 at cycle 2 with err=0; count=1.
2. Requester 0 pushes 16 times (0x01..0x10), then pushes 8'hFF → 17th response has err=1, no stk_push pulse, count stays 16, full=1.
3. Both requesters hold pop continuously on a full stack → grants alternate 1,0,1,0… (after rr_ptr=1 from scenario 2). rsp_data sequence is 0x10, 0x0F, … down to 0x01. The next pop returns err=1 and empty=1.
4. Requester 1 asserts push and pop together → rsp_valid=2'b10, err=1 at cycle 1; no stack strobe.
5. Push three values, then assert flush for 1 cycle → stk_clear pulses once, count=0. A pop then returns err=1.
6. Assert reset during WAIT of a pop → outputs return to reset values immediately, with no rsp_valid. Force stk_error=1 while IDLE → fault=1 and stays set until reset.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the stack arbiter: FSM states, opcodes,
// response codes and a helper for index widths.
package stack_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        FLUSH
    } state_e;

    // Operation latched for the granted requester.
    typedef enum logic {
        OP_PUSH,
        OP_POP
    } op_e;

    // Values carried on rsp_err alongside rsp_valid.
    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // Width of a binary index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// Client-side request/response bus shared by all requesters of the stack.
// master = client logic, slave = stack_arbiter.
interface stack_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req_push;
    logic [NUM_REQ-1:0]        req_pop;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      flush;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    modport master (
        output req_push,
        output req_pop,
        output req_data,
        output flush,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_push,
        input  req_pop,
        input  req_data,
        input  flush,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// rr_ptr, wrapping around. The pointer itself lives in the caller.
module rr_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan requesters starting at rr_ptr and keep the first one found.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        if (enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pos = int'(rr_ptr) + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                pos_idx = IDX_W'(pos);
                if (!any && req[pos_idx]) begin
                    any          = 1'b1;
                    grant[pos_idx] = 1'b1;
                    idx          = pos_idx;
                end
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin front end for a single LIFO stack shared by NUM_REQ clients.
// Runs one stack operation at a time, tracks occupancy so overflow and
// underflow are refused before the stack sees them, and returns pop data
// plus a status to the requester that was served.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 8,
    parameter int STACK_LAT = 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    stack_arbiter_if.slave    cli,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_in,
    output logic              stk_clear,
    input  logic [DATA_W-1:0] stk_data_out,
    input  logic              stk_error,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              fault
);

    localparam int               IDX_W   = idx_width(NUM_REQ);
    localparam int               LAT_W   = (STACK_LAT > 1) ? $clog2(STACK_LAT) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // FSM and transaction context.
    state_e            state_q,       state_d;
    op_e               op_q,          op_d;
    logic [IDX_W-1:0]  winner_q,      winner_d;
    logic [IDX_W-1:0]  rr_ptr_q,      rr_ptr_d;
    logic [LAT_W-1:0]  wait_cnt_q,    wait_cnt_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic              issued_q,      issued_d;
    logic              fault_q,       fault_d;

    // Registered outputs.
    logic              stk_push_q,    stk_push_d;
    logic              stk_pop_q,     stk_pop_d;
    logic [DATA_W-1:0] stk_data_in_q, stk_data_in_d;
    logic              flush_pulse_q, flush_pulse_d;
    logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
    logic              rsp_err_q,     rsp_err_d;

    // Arbitration.
    logic [NUM_REQ-1:0] req_any;
    logic               arb_en;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               win_push;
    logic               win_pop;
    logic [DATA_W-1:0]  win_data;
    logic               full_w;
    logic               empty_w;

    // Arbitration only matters in IDLE, and flush outranks every request.
    assign req_any = cli.req_push | cli.req_pop;
    assign arb_en  = (state_q == IDLE) && !cli.flush;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req_any),
        .rr_ptr (rr_ptr_q),
        .enable (arb_en),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign win_push = cli.req_push[arb_idx];
    assign win_pop  = cli.req_pop[arb_idx];
    assign win_data = cli.req_data[int'(arb_idx) * DATA_W +: DATA_W];

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // Next-state and output logic for the one-operation-at-a-time FSM.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        winner_d      = winner_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        count_d       = count_q;
        // The stack legitimately reports errors only in the cycle after ISSUE.
        issued_d      = (state_q == ISSUE);
        fault_d       = fault_q | (stk_error & ~issued_q);
        stk_push_d    = 1'b0;
        stk_pop_d     = 1'b0;
        stk_data_in_d = '0;
        flush_pulse_d = 1'b0;
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        rsp_err_d     = RSP_OK;

        unique case (state_q)
            IDLE: begin
                if (cli.flush) begin
                    flush_pulse_d = 1'b1;
                    state_d       = FLUSH;
                end else if (arb_any) begin
                    winner_d = arb_idx;
                    op_d     = win_pop ? OP_POP : OP_PUSH;
                    if ((win_push && win_pop) ||
                        (win_push && full_w)  ||
                        (win_pop  && empty_w)) begin
                        // Refused without touching the stack.
                        rsp_valid_d = arb_grant;
                        rsp_err_d   = RSP_ERR;
                        state_d     = RESP;
                    end else if (win_push) begin
                        stk_push_d    = 1'b1;
                        stk_data_in_d = win_data;
                        state_d       = ISSUE;
                    end else begin
                        stk_pop_d = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (op_q == OP_PUSH) begin
                    count_d               = count_q + 1'b1;
                    rsp_valid_d[winner_q] = 1'b1;
                    state_d               = RESP;
                end else begin
                    count_d    = count_q - 1'b1;
                    wait_cnt_d = LAT_W'(STACK_LAT - 1);
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_valid_d[winner_q] = 1'b1;
                    rsp_data_d            = stk_data_out;
                    state_d               = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end

            RESP: begin
                rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
                state_d  = IDLE;
            end

            FLUSH: begin
                count_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= OP_PUSH;
            winner_q      <= '0;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            count_q       <= '0;
            issued_q      <= 1'b0;
            fault_q       <= 1'b0;
            stk_push_q    <= 1'b0;
            stk_pop_q     <= 1'b0;
            stk_data_in_q <= '0;
            flush_pulse_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= RSP_OK;
        end else begin
            // NOTE: non-blocking assignments make every register take its new value together at the edge.
            state_q       <= state_d;
            op_q          <= op_d;
            winner_q      <= winner_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            fault_q       <= fault_d;
            stk_push_q    <= stk_push_d;
            stk_pop_q     <= stk_pop_d;
            stk_data_in_q <= stk_data_in_d;
            flush_pulse_q <= flush_pulse_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign stk_push      = stk_push_q;
    assign stk_pop       = stk_pop_q;
    assign stk_data_in   = stk_data_in_q;
    assign stk_clear     = reset | flush_pulse_q;
    assign cli.rsp_valid = rsp_valid_q;
    assign cli.rsp_data  = rsp_data_q;
    assign cli.rsp_err   = rsp_err_q;
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign busy          = (state_q != IDLE);
    assign fault         = fault_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small behavioural LIFO attached.
module tb_stack_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    stack_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    logic          stk_push, stk_pop, stk_clear, stk_error;
    logic [DW-1:0] stk_data_in, stk_data_out;
    logic [4:0]    count;
    logic          full, empty, busy, fault;
    logic          err_force;

    stack_arbiter #(
        .NUM_REQ   (NR),
        .DEPTH     (DEP),
        .DATA_W    (DW),
        .STACK_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cli          (bus),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_clear    (stk_clear),
        .stk_data_out (stk_data_out),
        .stk_error    (stk_error),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: one-cycle read latency, error registered.
    logic [DW-1:0] mem [DEP];
    logic [4:0]    sp;
    logic          mdl_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp           <= '0;
            stk_data_out <= '0;
            mdl_err      <= 1'b0;
        end else begin
            mdl_err <= 1'b0;
            if (stk_clear) begin
                sp <= '0;
            end else if (stk_push) begin
                if (sp == 5'(DEP)) mdl_err <= 1'b1;
                else begin
                    mem[sp[3:0]] <= stk_data_in;
                    sp           <= sp + 5'd1;
                end
            end else if (stk_pop) begin
                if (sp == 5'd0) mdl_err <= 1'b1;
                else begin
                    stk_data_out <= mem[sp[3:0] - 4'd1];
                    sp           <= sp - 5'd1;
                end
            end
        end
    end

    assign stk_error = mdl_err | err_force;

    // Event monitor.
    int cyc = 0;
    int push_seen = 0, pop_seen = 0, clear_seen = 0, rsp_seen = 0, last_strobe_cyc = 0;
    bit both_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (stk_push) begin
                push_seen       <= push_seen + 1;
                last_strobe_cyc <= cyc;
            end
            if (stk_pop) begin
                pop_seen        <= pop_seen + 1;
                last_strobe_cyc <= cyc;
            end
            if (stk_push && stk_pop) both_seen <= 1'b1;
            if (stk_clear) clear_seen <= clear_seen + 1;
            if (bus.rsp_valid != '0) rsp_seen <= rsp_seen + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int         r;
        bit         p;
        bit         q;
        logic [7:0] d;
        logic [1:0] exp_vld;
        bit         exp_err;
        logic [7:0] exp_data;
        int         exp_lat;
        int         exp_push;
        int         exp_pop;
        int         exp_cnt;
    } vec_t;

    function automatic vec_t mk(int r, bit p, bit q, logic [7:0] d, logic [1:0] vld, bit err,
                                logic [7:0] data, int lat, int np, int nq, int cnt);
        vec_t v;
        v.r = r; v.p = p; v.q = q; v.d = d; v.exp_vld = vld; v.exp_err = err;
        v.exp_data = data; v.exp_lat = lat; v.exp_push = np; v.exp_pop = nq; v.exp_cnt = cnt;
        return v;
    endfunction

    // One request held until its response, then dropped in the following IDLE cycle.
    task automatic run_txn(input int r, input bit p, input bit q, input logic [7:0] d,
                           output logic [1:0] vld, output logic err, output logic [7:0] data,
                           output int lat, output int n_push, output int n_pop, output int ofs);
        int  p0, q0, c0;
        bit  done;
        p0 = push_seen; q0 = pop_seen; c0 = cyc; done = 1'b0;
        lat = -1; vld = '0; err = 1'b0; data = '0;
        bus.req_data = '0;
        bus.req_data[r*DW +: DW] = d;
        bus.req_push = '0;
        bus.req_pop  = '0;
        bus.req_push[r] = p;
        bus.req_pop[r]  = q;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                vld = bus.rsp_valid; err = bus.rsp_err; data = bus.rsp_data;
                lat = c; done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.req_push = '0;
        bus.req_pop  = '0;
        bus.req_data = '0;
        n_push = push_seen - p0;
        n_pop  = pop_seen - q0;
        ofs    = last_strobe_cyc - c0;
    endtask

    // Wait (bounded) for the next response while requests stay as they are.
    task automatic wait_rsp(output logic [1:0] vld, output logic err, output logic [7:0] data);
        bit done;
        done = 1'b0; vld = '0; err = 1'b0; data = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                vld = bus.rsp_valid; err = bus.rsp_err; data = bus.rsp_data; done = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[$];
        logic [1:0] vld;
        logic       err;
        logic [7:0] data;
        int         lat, np, nq, ofs, c0, r0;

        bus.req_push = '0;
        bus.req_pop  = '0;
        bus.req_data = '0;
        bus.flush    = 1'b0;
        err_force    = 1'b0;

        // Reset state.
        #1;
        check("rst_stk_clear", stk_clear, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_stk_push", stk_push, 0);
        check("rst_stk_pop", stk_pop, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("post_rst_stk_clear", stk_clear, 0);
        @(posedge clk); #1;

        // Single-transaction vectors: r, push, pop, data, vld, err, rsp_data, lat, #push, #pop, count.
        tbl.push_back(mk(0, 0, 1, 8'h00, 2'b01, 1, 8'h00, 1, 0, 0, 0));  // pop on empty
        tbl.push_back(mk(1, 1, 1, 8'h3C, 2'b10, 1, 8'h00, 1, 0, 0, 0));  // push+pop illegal
        tbl.push_back(mk(0, 1, 0, 8'hAA, 2'b01, 0, 8'h00, 2, 1, 0, 1));  // push AA
        tbl.push_back(mk(0, 0, 1, 8'h00, 2'b01, 0, 8'hAA, 3, 0, 1, 0));  // pop AA
        for (int k = 0; k < 16; k++) begin
            tbl.push_back(mk(0, 1, 0, 8'(k + 1), 2'b01, 0, 8'h00, 2, 1, 0, k + 1));
        end
        tbl.push_back(mk(0, 1, 0, 8'hFF, 2'b01, 1, 8'h00, 1, 0, 0, 16)); // push on full

        foreach (tbl[i]) begin
            run_txn(tbl[i].r, tbl[i].p, tbl[i].q, tbl[i].d, vld, err, data, lat, np, nq, ofs);
            check($sformatf("v%0d_rsp_valid", i), vld, tbl[i].exp_vld);
            check($sformatf("v%0d_rsp_err", i), err, tbl[i].exp_err);
            check($sformatf("v%0d_rsp_data", i), data, tbl[i].exp_data);
            check($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
            check($sformatf("v%0d_push_strobes", i), np, tbl[i].exp_push);
            check($sformatf("v%0d_pop_strobes", i), nq, tbl[i].exp_pop);
            check($sformatf("v%0d_count", i), count, tbl[i].exp_cnt);
            if (tbl[i].exp_push + tbl[i].exp_pop > 0) begin
                check($sformatf("v%0d_strobe_cycle", i), ofs, 1);
            end
        end
        check("full_after_16", full, 1);
        check("not_empty_after_16", empty, 0);

        // Both requesters pop continuously: grants alternate starting at requester 1.
        c0 = pop_seen;
        bus.req_pop = 2'b11;
        for (int k = 0; k < 17; k++) begin
            wait_rsp(vld, err, data);
            if (k < 16) begin
                check($sformatf("rr%0d_grant", k), vld, (k % 2 == 0) ? 2'b10 : 2'b01);
                check($sformatf("rr%0d_err", k), err, 0);
                check($sformatf("rr%0d_data", k), data, 16 - k);
            end else begin
                check("rr_last_grant", vld, 2'b10);
                check("rr_last_err", err, 1);
                check("rr_last_empty", empty, 1);
            end
        end
        @(posedge clk); #1;
        bus.req_pop = '0;
        check("rr_pop_strobes", pop_seen - c0, 16);

        // Push three, flush, then a pop must be refused.
        for (int k = 0; k < 3; k++) begin
            run_txn(0, 1, 0, 8'(8'h11 * (k + 1)), vld, err, data, lat, np, nq, ofs);
        end
        check("pre_flush_count", count, 3);
        c0 = clear_seen;
        r0 = rsp_seen;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", busy, 1);
        @(posedge clk); #1;
        check("flush_clear_pulses", clear_seen - c0, 1);
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_no_rsp", rsp_seen - r0, 0);
        run_txn(1, 0, 1, 8'h00, vld, err, data, lat, np, nq, ofs);
        check("post_flush_pop_vld", vld, 2'b10);
        check("post_flush_pop_err", err, 1);
        check("post_flush_pop_lat", lat, 1);
        check("post_flush_pop_strobes", nq, 0);

        // Reset during WAIT of a pop aborts it without a response.
        run_txn(0, 1, 0, 8'h5A, vld, err, data, lat, np, nq, ofs);
        check("pre_abort_count", count, 1);
        r0 = rsp_seen;
        bus.req_pop[1] = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_stk_clear", stk_clear, 1);
        check("abort_empty", empty, 1);
        check("abort_count", count, 0);
        bus.req_pop = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort_no_rsp", rsp_seen - r0, 0);

        // stk_error in the cycle after ISSUE does not raise fault.
        bus.req_data = 16'h0077;
        bus.req_push = 2'b01;
        @(posedge clk);
        @(posedge clk); #1;
        err_force = 1'b1;
        @(posedge clk); #1;
        err_force    = 1'b0;
        bus.req_push = '0;
        bus.req_data = '0;
        @(negedge clk);
        check("exempt_fault", fault, 0);
        check("exempt_count", count, 1);

        // stk_error while IDLE sets a sticky fault cleared only by reset.
        @(posedge clk); #1;
        err_force = 1'b1;
        @(posedge clk); #1;
        err_force = 1'b0;
        check("idle_fault_set", fault, 1);
        repeat (5) @(posedge clk);
        #1 check("idle_fault_sticky", fault, 1);
        reset = 1'b1;
        #1 check("fault_cleared_by_reset", fault, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        check("never_push_and_pop", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
